multdiv_unit: RTL and testbench

- Sequential signed 32-bit multiplier/divider used by the Execute stage of the 5-stage pipeline.
- Execute issues a one-cycle start pulse for a mult or div ALU op.
- While the op is in flight, Execute holds the pipeline frozen. It uses data_resultRDY to release the freeze and to select data_result as the X-stage result.
- data_exception drives the mult/div overflow bits of the rstatus setx instruction.

---
 rtl/multdiv_unit.sv | 156 +++++++++++++++
 tb/tb_multdiv_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Sequential signed multiplier/divider for the Execute stage.
// Multiply: radix-4 Booth, one digit per cycle. Divide: restoring, one bit per cycle.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned RW    = WIDTH + 1;
  localparam logic [CNT_W-1:0] MULT_STEPS = CNT_W'(WIDTH / 2);
  localparam logic [CNT_W-1:0] DIV_STEPS  = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] counter;
  logic [PW-1:0]    mcand;       // shifted multiplicand (mult)
  logic [WIDTH-1:0] mplr;        // multiplier (mult) / dividend-quotient shifter (div)
  logic             boothPrev;   // bit to the right of the current Booth pair
  logic [PW-1:0]    acc;         // product (mult) / remainder in low bits (div)
  logic [WIDTH-1:0] divisorMag;
  logic             negQuot;
  logic             divZero;
  logic             divOvf;

  logic             start;
  logic [WIDTH-1:0] aMag, bMag;
  logic [PW-1:0]    boothAddend;
  logic [RW-1:0]    divShifted, divDiff, newRem;
  logic [WIDTH-1:0] mulResult, divResult;
  logic             mulOverflow, divException;
  logic [WIDTH:0]   productTop;

  assign start = ctrl_MULT | ctrl_DIV;

  // Operand magnitudes; MIN_INT negates to the unsigned value 2^(WIDTH-1).
  always_comb begin
    aMag = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
    bMag = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;
  end

  // Radix-4 Booth digit selection.
  always_comb begin
    boothAddend = '0;
    case ({mplr[1:0], boothPrev})
      3'b001, 3'b010: boothAddend = mcand;
      3'b011:         boothAddend = mcand << 1;
      3'b100:         boothAddend = PW'(-(mcand << 1));
      3'b101, 3'b110: boothAddend = PW'(-mcand);
      default:        boothAddend = '0;
    endcase
  end

  // Restoring-division trial subtract and final result formatting.
  always_comb begin
    divShifted   = {acc[WIDTH-1:0], mplr[WIDTH-1]};
    divDiff      = divShifted - {1'b0, divisorMag};
    newRem       = divDiff[RW-1] ? divShifted : divDiff;
    mulResult    = acc[WIDTH-1:0];
    productTop   = acc[PW-1:WIDTH-1];
    mulOverflow  = !((&productTop) || (~|productTop));
    divException = divZero | divOvf;
    if (divZero)      divResult = '0;
    else if (divOvf)  divResult = MIN_INT;
    else if (negQuot) divResult = WIDTH'(-mplr);
    else              divResult = mplr;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; a start pre-empts whatever is in flight.
  always_comb begin
    stateNext = state;
    if (ctrl_MULT) begin
      stateNext = MULT;
    end else if (ctrl_DIV) begin
      stateNext = DIV;
    end else begin
      case (state)
        MULT:    if (counter == MULT_STEPS) stateNext = DONE;
        DIV:     if (counter == DIV_STEPS)  stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Datapath: operand capture on start, one Booth digit or quotient bit per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter    <= '0;
      mcand      <= '0;
      mplr       <= '0;
      boothPrev  <= 1'b0;
      acc        <= '0;
      divisorMag <= '0;
      negQuot    <= 1'b0;
      divZero    <= 1'b0;
      divOvf     <= 1'b0;
    end else if (start) begin
      counter    <= '0;
      mcand      <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      mplr       <= ctrl_MULT ? data_operandB : aMag;
      boothPrev  <= 1'b0;
      acc        <= '0;
      divisorMag <= bMag;
      negQuot    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divZero    <= (data_operandB == '0);
      divOvf     <= (data_operandA == MIN_INT) && (data_operandB == '1);
    end else if (state == MULT && counter != MULT_STEPS) begin
      acc       <= acc + boothAddend;
      mcand     <= mcand << 2;
      mplr      <= mplr >> 2;
      boothPrev <= mplr[1];
      counter   <= counter + CNT_W'(1);
    end else if (state == DIV && counter != DIV_STEPS) begin
      acc     <= PW'(newRem);
      mplr    <= {mplr[WIDTH-2:0], ~divDiff[RW-1]};
      counter <= counter + CNT_W'(1);
    end
  end

  // Registered outputs: result/exception load only on entry to DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (stateNext == DONE);
      if (stateNext == DONE && state == MULT) begin
        data_result    <= mulResult;
        data_exception <= mulOverflow;
      end else if (stateNext == DONE && state == DIV) begin
        data_result    <= divResult;
        data_exception <= divException;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, single RDY pulse, results, aborts, reset.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int nCompared   = 0;
  int nMismatched = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive operands and a one-cycle start; returns #1 after the accepting edge.
  task automatic startOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
  endtask

  // Watch a bounded window after the start edge and check the RDY pulse and result.
  task automatic waitAndCheck(input string tag, input int lat,
                              input logic [31:0] expRes, input logic expExc);
    int firstK = -1;
    int pulses = 0;
    logic [31:0] res = 32'hX;
    logic exc = 1'bX;
    for (int k = 1; k <= lat + 3; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        pulses++;
        if (firstK < 0) begin
          firstK = k;
          res = data_result;
          exc = data_exception;
        end
      end
    end
    checkVal({tag, "_lat"}, firstK, lat);
    checkVal({tag, "_pulses"}, pulses, 1);
    checkVal({tag, "_res"}, res, expRes);
    checkVal({tag, "_exc"}, {31'b0, exc}, {31'b0, expExc});
    checkVal({tag, "_held"}, data_result, expRes);
  endtask

  task automatic runOp(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic expExc);
    startOp(m, d, a, b);
    waitAndCheck(tag, m ? 17 : 33, expRes, expExc);
  endtask

  initial begin
    int rdySeen;
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    checkVal("rst_res", data_result, 32'h0);
    checkVal("rst_exc", {31'b0, data_exception}, 32'h0);
    checkVal("rst_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Multiply vectors
    runOp("mul_7xm3",   1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    runOp("mul_ovf",    1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    runOp("mul_m1xm1",  1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    runOp("mul_minx1",  1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    runOp("mul_minxm1", 1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Divide vectors
    runOp("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
    runOp("div_100_m7", 1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    runOp("div_by0",    1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
    runOp("div_minm1",  1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    runOp("div_min_2",  1'b0, 1'b1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0);

    // Abort a divide with a multiply at edge N+10
    startOp(1'b0, 1'b1, 32'd50, 32'd5);
    rdySeen = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdySeen++;
    end
    checkVal("abort_norddy", rdySeen, 0);
    runOp("abort_mul", 1'b1, 1'b0, 32'd6, 32'd6, 32'd36, 1'b0);

    // Reset mid-multiply: outputs clear at once, no RDY afterwards
    startOp(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkVal("midrst_res", data_result, 32'h0);
    checkVal("midrst_exc", {31'b0, data_exception}, 32'h0);
    checkVal("midrst_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    rdySeen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdySeen++;
    end
    checkVal("midrst_nordy", rdySeen, 0);
    runOp("mul_3x4", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);

    // Both controls high: multiply wins
    runOp("both_hi", 1'b1, 1'b1, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFF6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
